// File: rtl/mouse_pkg.sv
// Shared constants and helpers for the mouse quadrature encoder: bundle bit map,
// Gray-code lookup and the symmetric saturating adder used by each axis.
package mouse_pkg;

    localparam int ACC_W_DEF = 12;

    localparam int MB_Y1  = 0;
    localparam int MB_Y2  = 1;
    localparam int MB_X1  = 2;
    localparam int MB_X2  = 3;
    localparam int MB_BTN = 4;

    // Phase 0..3 to {A2,A1}; adjacent phases differ in exactly one bit.
    function automatic logic [1:0] gray2(input logic [1:0] p);
        case (p)
            2'd0:    gray2 = 2'b00;
            2'd1:    gray2 = 2'b01;
            2'd2:    gray2 = 2'b11;
            default: gray2 = 2'b10;
        endcase
    endfunction

    // Clamp a + b to the symmetric range +/-(2^(w-1)-1) so negation never overflows.
    function automatic int sat_add(input int a, input int b, input int w);
        int lim;
        int s;
        lim = (1 << (w - 1)) - 1;
        s   = a + b;
        if (s > lim)
            return lim;
        if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/quad_axis.sv
// One quadrature axis: pending-motion accumulator, step-rate divider and
// registered Gray-coded phase output.
module quad_axis
    import mouse_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int STEP_DIV = 400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    strobe,
    input  logic signed [ACC_W-1:0] delta,
    output logic [1:0]              quad,
    output logic                    nonzero
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              quad_q, quad_d;
    logic                    nz_q, nz_d;
    logic                    step;
    int                      step_dir;

    always_comb begin
        cnt_d    = cnt_q;
        step     = 1'b0;
        step_dir = 0;
        // Divider idles at zero so the first step lands STEP_DIV enables after motion arrives.
        if (acc_q == '0) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_W'(STEP_DIV - 1)) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (step)
            step_dir = acc_q[ACC_W-1] ? -1 : 1;

        // A strobe and a step in the same cycle are folded into one update.
        acc_d   = ACC_W'(sat_add(int'(acc_q), (strobe ? int'(delta) : 0) - step_dir, ACC_W));
        phase_d = phase_q + (step ? (acc_q[ACC_W-1] ? 2'b11 : 2'b01) : 2'b00);
        quad_d  = gray2(phase_d);
        nz_d    = (acc_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            quad_q  <= '0;
            nz_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            quad_q  <= quad_d;
            nz_q    <= nz_d;
        end
    end

    assign quad    = quad_q;
    assign nonzero = nz_q;

endmodule

// File: rtl/mouse_quadrature.sv
// Mouse packet to quadrature bundle converter: captures X/Y deltas and button,
// replays motion as rate-limited Gray steps. Optional MOUSE_ACCEL_EN doubles large deltas.
module mouse_quadrature
    import mouse_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int STEP_DIV = 400,
    parameter int INVERT_Y = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mouse_strobe,
    input  logic signed [8:0] dx,
    input  logic signed [8:0] dy,
    input  logic              btn,
    output logic [4:0]        mouse,
    output logic              busy
);

    // ACC_W must be at least 10 so that -(-256) is representable.
    logic signed [ACC_W-1:0] dx_ext, dy_ext;
    logic signed [ACC_W-1:0] dx_acc, dy_acc;
    logic                    btn_q, btn_d;
    logic [1:0]              x_quad, y_quad;
    logic                    x_nz, y_nz;

`ifdef MOUSE_ACCEL_EN
    localparam logic signed [ACC_W-1:0] ACCEL_TH = ACC_W'(8);

    // Beyond +/-8 the slope doubles, offset so the curve is continuous at the knee.
    function automatic logic signed [ACC_W-1:0] accel(input logic signed [ACC_W-1:0] d);
        if (d > ACCEL_TH)
            accel = (d <<< 1) - ACCEL_TH;
        else if (d < -ACCEL_TH)
            accel = (d <<< 1) + ACCEL_TH;
        else
            accel = d;
    endfunction
`endif

    always_comb begin
        dx_ext = ACC_W'(dx);
        dy_ext = ACC_W'(dy);
        if (INVERT_Y != 0)
            dy_ext = -dy_ext;
`ifdef MOUSE_ACCEL_EN
        dx_acc = accel(dx_ext);
        dy_acc = accel(dy_ext);
`else
        dx_acc = dx_ext;
        dy_acc = dy_ext;
`endif
        btn_d = mouse_strobe ? btn : btn_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            btn_q <= 1'b0;
        else
            btn_q <= btn_d;
    end

    quad_axis #(.ACC_W(ACC_W), .STEP_DIV(STEP_DIV)) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .strobe  (mouse_strobe),
        .delta   (dx_acc),
        .quad    (x_quad),
        .nonzero (x_nz)
    );

    quad_axis #(.ACC_W(ACC_W), .STEP_DIV(STEP_DIV)) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .strobe  (mouse_strobe),
        .delta   (dy_acc),
        .quad    (y_quad),
        .nonzero (y_nz)
    );

    always_comb begin
        mouse         = '0;
        mouse[MB_Y1]  = y_quad[0];
        mouse[MB_Y2]  = y_quad[1];
        mouse[MB_X1]  = x_quad[0];
        mouse[MB_X2]  = x_quad[1];
        mouse[MB_BTN] = ~btn_q;
    end

    assign busy = x_nz | y_nz;

endmodule

// File: tb/tb_mouse_quadrature.sv
// Scoreboard bench for mouse_quadrature: each packet pushes its expected bundle
// edges; a monitor pops and compares them as the outputs change.
module tb_mouse_quadrature;

    localparam int SD = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              mouse_strobe;
    logic signed [8:0] dx, dy;
    logic              btn;
    logic [4:0]        mouse;
    logic              busy;

    typedef struct {
        logic [4:0] m;
        logic       b;
        bit         timed;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         en_cnt = 0;
    int         last_en = 0;
    int         en_mode = 1;
    bit         mon_en = 1'b0;
    logic [4:0] prev_mouse = 5'b10000;
    int         xph = 0, yph = 0;
    logic       mbtn = 1'b0;

    mouse_quadrature #(.ACC_W(12), .STEP_DIV(SD), .INVERT_Y(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mouse_strobe (mouse_strobe),
        .dx           (dx),
        .dy           (dy),
        .btn          (btn),
        .mouse        (mouse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] g(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [4:0] mk();
        return {~mbtn, g(xph), g(yph)};
    endfunction

    task automatic push_steps(input bit is_x, input int n, input int dir, input bit clears);
        for (int i = 0; i < n; i++) begin
            if (is_x) xph += dir;
            else      yph += dir;
            exp_q.push_back('{m: mk(), b: !(clears && i == n - 1), timed: 1'b1});
        end
    endtask

    // Caller is just after a clock edge; strobe covers exactly the next edge.
    task automatic send(input int sdx, input int sdy, input logic b);
        dx = 9'(sdx);
        dy = 9'(sdy);
        btn = b;
        mouse_strobe = 1'b1;
        @(posedge clk);
        #1;
        mouse_strobe = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < max_cyc) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0:       en = 1'b0;
                1:       en = 1'b1;
                default: en = ~en;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (en === 1'b1) en_cnt++;
            #2;
            if (mon_en && mouse !== prev_mouse) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_edge", mouse, prev_mouse);
                end else begin
                    e = exp_q.pop_front();
                    chk("mouse", mouse, e.m);
                    chk("busy_at_edge", busy, e.b);
                    if (e.timed) chk("step_gap", en_cnt - last_en, SD);
                    last_en = en_cnt;
                end
            end
            prev_mouse = mouse;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        mouse_strobe = 1'b0;
        dx = '0;
        dy = '0;
        btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mouse", mouse, 5'b10000);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // X +3 with en every other clock
        en_mode = 2;
        push_steps(1'b1, 3, 1, 1'b1);
        send(3, 0, 1'b0);
        last_en = en_cnt;
        wait_drain("x3", 3 * SD * 2 + 40);

        // Y +2, inverted to down-steps
        en_mode = 1;
        push_steps(1'b0, 2, -1, 1'b1);
        send(0, 2, 1'b0);
        last_en = en_cnt;
        wait_drain("y2", 2 * SD + 40);

        // Reversal: -10 lands on the third step edge, acc goes 2-10-1 = -9
        push_steps(1'b1, 3, 1, 1'b0);
        send(4, 0, 1'b0);
        last_en = en_cnt;
        repeat (3 * SD - 1) @(posedge clk);
        #1;
        push_steps(1'b1, 9, -1, 1'b1);
        send(-10, 0, 1'b0);
        wait_drain("rev", 9 * SD + 40);

        // Button press and release
        mbtn = 1'b1;
        exp_q.push_back('{m: mk(), b: 1'b0, timed: 1'b0});
        send(0, 0, 1'b1);
        chk("btn_press", mouse[4], 1'b0);
        mbtn = 1'b0;
        exp_q.push_back('{m: mk(), b: 1'b0, timed: 1'b0});
        send(0, 0, 1'b0);
        chk("btn_release", mouse[4], 1'b1);
        wait_drain("btn", 10);

        // dx = +12: 16 steps when accelerated, 12 otherwise
`ifdef MOUSE_ACCEL_EN
        n = 16;
`else
        n = 12;
`endif
        push_steps(1'b1, n, 1, 1'b1);
        send(12, 0, 1'b0);
        last_en = en_cnt;
        wait_drain("accel", n * SD + 40);

        // Saturation: 16 x -256 with en held low clamps at -2047
        en_mode = 0;
        @(posedge clk);
        #1;
        push_steps(1'b1, 2047, -1, 1'b1);
        for (int i = 0; i < 16; i++) send(-256, 0, 1'b0);
        chk("sat_busy", busy, 1);
        en_mode = 1;
        last_en = en_cnt;
        wait_drain("sat", 2047 * SD + 100);

        // Reset mid-drain after two of seven steps (acc = 5)
        push_steps(1'b1, 2, 1, 1'b0);
        send(7, 0, 1'b0);
        last_en = en_cnt;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * SD) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("pre_rst_left", exp_q.size(), 0);
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_mouse", mouse, 5'b10000);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3 * SD) @(posedge clk);
        #1;
        chk("rst_hold_mouse", mouse, 5'b10000);
        chk("rst_hold_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
